sysid_check_ctrl: RTL and testbench
===================================

SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 1800062834, meaning the system ID value expected at slave address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 1308259129, meaning the build timestamp expected at slave address 1.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of waitrequest-stalled cycles per read (range 1..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to run a check.
REQ-007 SHALL have port busy, output, 1 bit: high while a check is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-009 SHALL have port pass, output, 1 bit: both values matched and no timeout occurred.
REQ-010 SHALL have port id_mismatch, output, 1 bit: the captured ID differs from EXPECTED_ID.
REQ-011 SHALL have port ts_mismatch, output, 1 bit: the captured timestamp differs from EXPECTED_TS.
REQ-012 SHALL have port timeout_err, output, 1 bit: a read exceeded TIMEOUT stalled cycles.
REQ-013 SHALL have port id_value, output, 32 bits: the captured ID word.
REQ-014 SHALL have port ts_value, output, 32 bits: the captured timestamp word.
REQ-015 SHALL have port avm_address, output, 1 bit: the Avalon-MM master address to the sysid control slave.
REQ-016 SHALL have port avm_read, output, 1 bit: the Avalon-MM read strobe.
REQ-017 SHALL have port avm_readdata, input, 32 bits: the Avalon-MM read data.
REQ-018 SHALL have port avm_waitrequest, input, 1 bit: the slave stall signal; tie it low for the zero-wait-state sysid slave.

Function
REQ-019 SHALL implement the states IDLE, RD_ID, RD_TS and CHECK.
REQ-020 SHALL move IDLE->RD_ID when start=1 is sampled in IDLE; start SHALL be ignored in all other states.
REQ-021 SHALL drive avm_read=1, avm_address=0 in RD_ID and avm_read=1, avm_address=1 in RD_TS; avm_read SHALL be 0 in IDLE and CHECK.
REQ-022 SHALL accept a read on an edge where avm_read=1 and avm_waitrequest=0, capturing avm_readdata into id_value (RD_ID) or ts_value (RD_TS) with zero read latency.
REQ-023 SHALL hold avm_address and avm_read stable while avm_waitrequest=1.
REQ-024 SHALL move RD_ID->RD_TS and RD_TS->CHECK on acceptance; CHECK SHALL last exactly one cycle and then return to IDLE.
REQ-025 SHALL, on leaving CHECK, register id_mismatch=(id_value!=EXPECTED_ID), ts_mismatch=(ts_value!=EXPECTED_TS) and pass=~(id_mismatch|ts_mismatch|timeout_err), and pulse done=1 for exactly one cycle.
REQ-026 SHALL assert done in the cycle after the third edge following the edge that samples start, when no wait states occur; each stalled cycle SHALL add one cycle.
REQ-027 SHALL keep busy=1 in RD_ID, RD_TS and CHECK, and busy=0 in IDLE, including the done cycle.
REQ-028 SHALL clear the stall counter (16 bits) on entry to each read state and increment it on each cycle with avm_waitrequest=1.
REQ-029 SHALL, when the counter equals TIMEOUT while avm_waitrequest=1, drop avm_read on the next edge, set timeout_err=1 and go directly to CHECK; the mismatch flag of any uncompleted read SHALL be 0 and pass SHALL be 0.
REQ-030 SHALL hold pass, flag and value outputs from done until the next accepted start, and clear pass, flags and timeout_err on the edge that accepts start.
REQ-031 SHALL treat acceptance and timeout coinciding on the same edge as acceptance, with no timeout.

Reset
REQ-032 SHALL, with reset=1 at an edge, force IDLE and drive all outputs to 0 (busy, done, pass, flags, id_value, ts_value, avm_read, avm_address); reset SHALL take priority over start.
REQ-033 SHALL abandon a read in progress on reset mid-operation, with avm_read=0 from the next edge and no done pulse.

Verification
REQ-034 Bench SHALL cover: zero-wait slave returning 1800062834 / 1308259129, start pulse -> done on the 3rd edge after start, pass=1, flags 0.
REQ-035 Bench SHALL cover: slave returning ID 0x12345678 -> id_mismatch=1, ts_mismatch=0, pass=0, id_value=0x12345678.
REQ-036 Bench SHALL cover: TIMEOUT=4 and waitrequest stuck high in RD_TS -> avm_read held for 5 cycles, then timeout_err=1, pass=0, done pulse.
REQ-037 Bench SHALL cover: 2 wait states on each read -> done 4 cycles later than the zero-wait case, address stable during stalls.
REQ-038 Bench SHALL cover: start held high continuously -> back-to-back checks, start ignored while busy.
REQ-039 Bench SHALL cover: reset asserted in RD_ID -> all outputs 0 next edge, no done, and a new start completes normally.

Source files
------------

// File: rtl/sysid_check_ctrl.sv
// Reads the system ID and build timestamp from a sysid slave over Avalon-MM
// and reports whether both match the values this build expects.
//
// state | meaning
// IDLE  | waiting for start; results from the last check are held
// RD_ID | reading slave address 0 (system ID)
// RD_TS | reading slave address 1 (build timestamp)
// CHECK | one-cycle compare; results and done registered on exit
module sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID = 32'd1800062834,
   parameter logic [31:0] EXPECTED_TS = 32'd1308259129,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state;
   logic [15:0] stall_cnt;
   logic        id_got;
   logic        ts_got;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         stall_cnt   <= '0;
         id_got      <= 1'b0;
         ts_got      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         id_mismatch <= 1'b0;
         ts_mismatch <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RD_ID;
                  busy        <= 1'b1;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  stall_cnt   <= '0;
                  id_got      <= 1'b0;
                  ts_got      <= 1'b0;
                  pass        <= 1'b0;
                  id_mismatch <= 1'b0;
                  ts_mismatch <= 1'b0;
                  timeout_err <= 1'b0;
               end
            end

            RD_ID: begin
               // acceptance wins over a timeout on the same edge
               if (!avm_waitrequest) begin
                  id_value    <= avm_readdata;
                  id_got      <= 1'b1;
                  state       <= RD_TS;
                  avm_address <= 1'b1;
                  stall_cnt   <= '0;
               end else if (stall_cnt == TIMEOUT_CNT) begin
                  state       <= CHECK;
                  avm_read    <= 1'b0;
                  avm_address <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + 16'd1;
               end
            end

            RD_TS: begin
               if (!avm_waitrequest) begin
                  ts_value    <= avm_readdata;
                  ts_got      <= 1'b1;
                  state       <= CHECK;
                  avm_read    <= 1'b0;
                  avm_address <= 1'b0;
               end else if (stall_cnt == TIMEOUT_CNT) begin
                  state       <= CHECK;
                  avm_read    <= 1'b0;
                  avm_address <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + 16'd1;
               end
            end

            CHECK: begin
               // a read that never completed reports no mismatch
               state       <= IDLE;
               busy        <= 1'b0;
               done        <= 1'b1;
               id_mismatch <= id_got && (id_value != EXPECTED_ID);
               ts_mismatch <= ts_got && (ts_value != EXPECTED_TS);
               pass        <= !timeout_err && id_got && ts_got &&
                              (id_value == EXPECTED_ID) &&
                              (ts_value == EXPECTED_TS);
            end

            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               avm_read <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a small Avalon-MM sysid slave model
// that can insert wait states or stall the timestamp read indefinitely.
module tb_sysid_check_ctrl;

   localparam logic [31:0] EXP_ID = 32'd1800062834;
   localparam logic [31:0] EXP_TS = 32'd1308259129;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, pass, id_mismatch, ts_mismatch, timeout_err;
   logic [31:0] id_value, ts_value;
   logic        avm_address, avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   logic [31:0] id_word;
   logic [31:0] ts_word;
   int          wait_n;
   logic        stuck_ts;
   int          slv_stall;

   int tests = 0;
   int fails = 0;
   int lat, n_id, n_ts, done_seen;

   sysid_check_ctrl #(.TIMEOUT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .id_mismatch     (id_mismatch),
      .ts_mismatch     (ts_mismatch),
      .timeout_err     (timeout_err),
      .id_value        (id_value),
      .ts_value        (ts_value),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   // slave: wait_n stalls per read, or stall forever on address 1
   assign avm_readdata    = avm_address ? ts_word : id_word;
   assign avm_waitrequest = avm_read && ((slv_stall < wait_n) || (stuck_ts && avm_address));

   always @(posedge clk) begin
      if (!avm_read || !avm_waitrequest) slv_stall <= 0;
      else                               slv_stall <= slv_stall + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // pulse start for one cycle; returns at the negedge after the sampling edge
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts cycles from the start-sampling edge until done, plus read cycles per address
   task automatic wait_done(output int l, output int ni, output int nt);
      l = 0; ni = 0; nt = 0;
      while (!done && l < 100) begin
         if (avm_read) begin
            if (avm_address) nt++;
            else             ni++;
         end
         @(negedge clk);
         l++;
      end
      check("done_within_bound", 32'(l < 100), 32'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      id_word = EXP_ID; ts_word = EXP_TS;
      wait_n = 0; stuck_ts = 1'b0; slv_stall = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_read", 32'(avm_read), 32'd0);
      check("rst_id_value", id_value, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // matching zero-wait check
      pulse_start();
      check("zw_busy", 32'(busy), 32'd1);
      check("zw_read_addr0", {30'd0, avm_read, avm_address}, 32'd2);
      wait_done(lat, n_id, n_ts);
      check("zw_latency", 32'(lat), 32'd3);
      check("zw_pass", 32'(pass), 32'd1);
      check("zw_flags", {29'd0, id_mismatch, ts_mismatch, timeout_err}, 32'd0);
      check("zw_busy_at_done", 32'(busy), 32'd0);
      check("zw_id_value", id_value, EXP_ID);
      check("zw_ts_value", ts_value, EXP_TS);
      @(negedge clk);
      check("zw_done_one_cycle", 32'(done), 32'd0);
      check("zw_pass_held", 32'(pass), 32'd1);

      // ID mismatch
      id_word = 32'h1234_5678;
      pulse_start();
      check("idm_pass_cleared", 32'(pass), 32'd0);
      wait_done(lat, n_id, n_ts);
      check("idm_id_mismatch", 32'(id_mismatch), 32'd1);
      check("idm_ts_mismatch", 32'(ts_mismatch), 32'd0);
      check("idm_pass", 32'(pass), 32'd0);
      check("idm_id_value", id_value, 32'h1234_5678);
      id_word = EXP_ID;

      // timestamp read stalls past TIMEOUT=4
      stuck_ts = 1'b1;
      pulse_start();
      wait_done(lat, n_id, n_ts);
      check("to_ts_read_cycles", 32'(n_ts), 32'd5);
      check("to_latency", 32'(lat), 32'd7);
      check("to_timeout_err", 32'(timeout_err), 32'd1);
      check("to_pass", 32'(pass), 32'd0);
      check("to_flags", {30'd0, id_mismatch, ts_mismatch}, 32'd0);
      check("to_read_dropped", 32'(avm_read), 32'd0);
      stuck_ts = 1'b0;

      // two wait states on each read
      wait_n = 2;
      pulse_start();
      wait_done(lat, n_id, n_ts);
      check("ws_latency", 32'(lat), 32'd7);
      check("ws_addr0_cycles", 32'(n_id), 32'd3);
      check("ws_addr1_cycles", 32'(n_ts), 32'd3);
      check("ws_timeout_cleared", 32'(timeout_err), 32'd0);
      check("ws_pass", 32'(pass), 32'd1);
      wait_n = 0;

      // start held high: back-to-back checks
      start = 1'b1;
      @(negedge clk);
      wait_done(lat, n_id, n_ts);
      check("b2b_first_latency", 32'(lat), 32'd3);
      check("b2b_first_pass", 32'(pass), 32'd1);
      @(negedge clk);
      check("b2b_restart_busy", 32'(busy), 32'd1);
      check("b2b_restart_pass_cleared", 32'(pass), 32'd0);
      wait_done(lat, n_id, n_ts);
      check("b2b_second_latency", 32'(lat), 32'd3);
      start = 1'b0;
      @(negedge clk);
      check("b2b_idle_after_release", 32'(busy), 32'd0);

      // reset during RD_ID
      wait_n = 3;
      pulse_start();
      check("mr_in_rd_id", {30'd0, avm_read, avm_address}, 32'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mr_outputs_zero",
            {25'd0, busy, done, pass, id_mismatch, ts_mismatch, timeout_err, avm_read}, 32'd0);
      check("mr_addr_zero", 32'(avm_address), 32'd0);
      check("mr_values_zero", id_value | ts_value, 32'd0);
      done_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("mr_no_done", 32'(done_seen), 32'd0);
      wait_n = 0;
      pulse_start();
      wait_done(lat, n_id, n_ts);
      check("mr_recover_latency", 32'(lat), 32'd3);
      check("mr_recover_pass", 32'(pass), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
